// File: rtl/rtc_alarm_clock_pkg.sv
// Shared definitions for the BCD alarm clock: the digit layout, digit limits,
// the ASCII base, and pure helpers for the BCD time arithmetic (write legality,
// digit write, one-second advance, 12h hour conversion).
package rtc_alarm_clock_pkg;

  typedef logic [2:0] digit_sel_t;
  typedef logic [3:0] bcd_t;

  // {hr_hi, hr_lo, min_hi, min_lo, sec_hi, sec_lo}, 24 bits, 24h format
  typedef struct packed {
    bcd_t hr_hi;
    bcd_t hr_lo;
    bcd_t min_hi;
    bcd_t min_lo;
    bcd_t sec_hi;
    bcd_t sec_lo;
  } hms_t;

  localparam digit_sel_t SEC_LO = 3'd0;
  localparam digit_sel_t SEC_HI = 3'd1;
  localparam digit_sel_t MIN_LO = 3'd2;
  localparam digit_sel_t MIN_HI = 3'd3;
  localparam digit_sel_t HR_LO  = 3'd4;
  localparam digit_sel_t HR_HI  = 3'd5;

  localparam logic [7:0] ASCII_ZERO   = 8'h30;
  localparam bcd_t       LO_MAX       = 4'd9;  // any low digit
  localparam bcd_t       HI_MAX       = 4'd5;  // tens of seconds / minutes
  localparam bcd_t       HR_HI_MAX    = 4'd2;
  localparam bcd_t       HR_LO_MAX_20 = 4'd3;  // hr_lo limit once hr_hi is 2
  localparam hms_t       HMS_ZERO     = 24'h000000;

  // A write is legal only if the register it lands in still holds a valid time.
  function automatic logic digit_legal(input digit_sel_t sel, input bcd_t val, input hms_t cur);
    logic ok;
    ok = 1'b0;
    case (sel)
      SEC_LO, MIN_LO: ok = (val <= LO_MAX);
      SEC_HI, MIN_HI: ok = (val <= HI_MAX);
      HR_LO:          ok = (cur.hr_hi == HR_HI_MAX) ? (val <= HR_LO_MAX_20) : (val <= LO_MAX);
      HR_HI:          ok = (val < HR_HI_MAX) || ((val == HR_HI_MAX) && (cur.hr_lo <= HR_LO_MAX_20));
      default:        ok = 1'b0;
    endcase
    return ok;
  endfunction

  function automatic hms_t write_digit(input hms_t cur, input digit_sel_t sel, input bcd_t val);
    hms_t n;
    n = cur;
    case (sel)
      SEC_LO:  n.sec_lo = val;
      SEC_HI:  n.sec_hi = val;
      MIN_LO:  n.min_lo = val;
      MIN_HI:  n.min_hi = val;
      HR_LO:   n.hr_lo  = val;
      HR_HI:   n.hr_hi  = val;
      default: n = cur;
    endcase
    return n;
  endfunction

  // One-second BCD ripple; 23:59:59 wraps to 00:00:00.
  function automatic hms_t advance(input hms_t t);
    hms_t n;
    n = t;
    if (t.sec_lo != LO_MAX) begin
      n.sec_lo = t.sec_lo + 4'd1;
    end else begin
      n.sec_lo = 4'd0;
      if (t.sec_hi != HI_MAX) begin
        n.sec_hi = t.sec_hi + 4'd1;
      end else begin
        n.sec_hi = 4'd0;
        if (t.min_lo != LO_MAX) begin
          n.min_lo = t.min_lo + 4'd1;
        end else begin
          n.min_lo = 4'd0;
          if (t.min_hi != HI_MAX) begin
            n.min_hi = t.min_hi + 4'd1;
          end else begin
            n.min_hi = 4'd0;
            if ((t.hr_hi == HR_HI_MAX) && (t.hr_lo == HR_LO_MAX_20)) begin
              n.hr_hi = 4'd0;
              n.hr_lo = 4'd0;
            end else if (t.hr_lo == LO_MAX) begin
              n.hr_lo = 4'd0;
              n.hr_hi = t.hr_hi + 4'd1;
            end else begin
              n.hr_lo = t.hr_lo + 4'd1;
            end
          end
        end
      end
    end
    return n;
  endfunction

  function automatic logic [4:0] hour_bin(input hms_t t);
    return (5'(t.hr_hi) * 5'd10) + 5'(t.hr_lo);
  endfunction

  function automatic logic is_pm(input hms_t t);
    return (hour_bin(t) >= 5'd12);
  endfunction

  // 12h hour digits as {hi, lo} BCD: 0 -> 12, 13..23 -> 1..11.
  function automatic logic [7:0] hour12_bcd(input hms_t t);
    logic [4:0] h;
    logic [4:0] dh;
    h = hour_bin(t);
    if (h == 5'd0) begin
      dh = 5'd12;
    end else if (h > 5'd12) begin
      dh = h - 5'd12;
    end else begin
      dh = h;
    end
    if (dh >= 5'd10) begin
      return {4'd1, 4'(dh - 5'd10)};
    end else begin
      return {4'd0, dh[3:0]};
    end
  endfunction

endpackage

// File: rtl/rtc_alarm_clock_if.sv
// Digit-write bus of the alarm clock.
//  set_en  : one-cycle write strobe
//  set_tgt : 0 = time register, 1 = alarm register
//  sel     : digit index (0 sec_lo .. 5 hr_hi)
//  load    : BCD value
//  set_err : one-cycle pulse after a rejected write
interface rtc_alarm_clock_if;
  import rtc_alarm_clock_pkg::*;

  logic       set_en;
  logic       set_tgt;
  digit_sel_t sel;
  logic [3:0] load;
  logic       set_err;

  modport master (output set_en, set_tgt, sel, load, input set_err);
  modport slave  (input set_en, set_tgt, sel, load, output set_err);
endinterface

// File: rtl/rtc_alarm_clock_num2ascii.sv
// One BCD digit to its ASCII character ('0' + digit).
//  digit : BCD value 0..9
//  ch    : ASCII code
module rtc_alarm_clock_num2ascii
  import rtc_alarm_clock_pkg::*;
(
  input  logic [3:0] digit,
  output logic [7:0] ch
);
  assign ch = ASCII_ZERO + {4'd0, digit};
endmodule

// File: rtl/rtc_alarm_clock.sv
// HH:MM:SS BCD real-time clock with its own tick divider, per-digit set with
// range check, alarm with ring/ack/timeout and a 12/24h display path.
//  CLOCK_50, clr : clock, asynchronous active-high reset
//  run           : 1 = divider and time advance
//  bus           : digit-write bus (set_en/set_tgt/sel/load in, set_err out)
//  alarm_en/ack  : arm alarm / clear ringing
//  h12           : 12h display format
//  time_bcd, alarm_bcd, tick, ringing : registered state
//  disp_bcd, pm, ascii                : combinational display of time_bcd
module rtc_alarm_clock
  import rtc_alarm_clock_pkg::*;
#(
  parameter int CLK_FREQ  = 50_000_000,
  parameter int TICK_HZ   = 1,
  parameter int RING_SECS = 60
) (
  input  logic               CLOCK_50,
  input  logic               clr,
  input  logic               run,
  rtc_alarm_clock_if.slave   bus,
  input  logic               alarm_en,
  input  logic               alarm_ack,
  input  logic               h12,
  output logic [23:0]        time_bcd,
  output logic [23:0]        alarm_bcd,
  output logic [23:0]        disp_bcd,
  output logic               pm,
  output logic [47:0]        ascii,
  output logic               tick,
  output logic               ringing
);

  localparam int         DIV       = CLK_FREQ / TICK_HZ;
  localparam int         DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [7:0] RING_LAST = 8'(RING_SECS);

  logic [DIV_W-1:0] div_r;
  logic             tick_r;
  hms_t             time_r;
  hms_t             alarm_r;
  logic             ringing_r;
  logic [7:0]       ring_cnt_r;
  logic             set_err_r;

  hms_t       write_cur_s;
  logic       legal_s;
  logic       time_wr_s;
  logic       alarm_wr_s;
  logic       div_last_s;
  logic       adv_s;
  logic       match_s;
  logic       ring_clr_s;
  logic [7:0] hr12_s;

  // Legality is judged against the register being written.
  assign write_cur_s = bus.set_tgt ? alarm_r : time_r;
  assign legal_s     = digit_legal(bus.sel, bus.load, write_cur_s);
  assign time_wr_s   = bus.set_en && legal_s && !bus.set_tgt;
  assign alarm_wr_s  = bus.set_en && legal_s && bus.set_tgt;
  assign div_last_s  = run && (div_r == DIV_W'(DIV - 1));
  // A time write wins over a coinciding advance, which is then lost.
  assign adv_s       = div_last_s && !time_wr_s;
  // tick_r marks the cycle right after an advance, so only tick-driven
  // changes of time can start the alarm.
  assign match_s     = tick_r && alarm_en && (time_r == alarm_r);
  assign ring_clr_s  = alarm_ack || !alarm_en
                       || (ringing_r && tick_r && ((ring_cnt_r + 8'd1) == RING_LAST));

  // Divider and tick pulse
  always_ff @(posedge CLOCK_50 or posedge clr) begin
    if (clr) begin
      div_r  <= {DIV_W{1'b0}};
      tick_r <= 1'b0;
    end else if (time_wr_s) begin
      div_r  <= {DIV_W{1'b0}};
      tick_r <= 1'b0;
    end else if (run) begin
      div_r  <= div_last_s ? {DIV_W{1'b0}} : (div_r + DIV_W'(1));
      tick_r <= div_last_s;
    end else begin
      div_r  <= div_r;
      tick_r <= 1'b0;
    end
  end

  // Time register: write, else advance, else hold
  always_ff @(posedge CLOCK_50 or posedge clr) begin
    if (clr) begin
      time_r <= HMS_ZERO;
    end else if (time_wr_s) begin
      time_r <= write_digit(time_r, bus.sel, bus.load);
    end else if (adv_s) begin
      time_r <= advance(time_r);
    end else begin
      time_r <= time_r;
    end
  end

  // Alarm register
  always_ff @(posedge CLOCK_50 or posedge clr) begin
    if (clr) begin
      alarm_r <= HMS_ZERO;
    end else if (alarm_wr_s) begin
      alarm_r <= write_digit(alarm_r, bus.sel, bus.load);
    end else begin
      alarm_r <= alarm_r;
    end
  end

  // Ringing flag and ring-duration counter; clearing beats a new match
  always_ff @(posedge CLOCK_50 or posedge clr) begin
    if (clr) begin
      ringing_r  <= 1'b0;
      ring_cnt_r <= 8'd0;
    end else if (ring_clr_s) begin
      ringing_r  <= 1'b0;
      ring_cnt_r <= 8'd0;
    end else if (ringing_r && tick_r) begin
      ring_cnt_r <= ring_cnt_r + 8'd1;
    end else if (match_s) begin
      ringing_r  <= 1'b1;
      ring_cnt_r <= 8'd0;
    end else begin
      ringing_r  <= ringing_r;
      ring_cnt_r <= ring_cnt_r;
    end
  end

  // Rejected-write pulse
  always_ff @(posedge CLOCK_50 or posedge clr) begin
    if (clr) begin
      set_err_r <= 1'b0;
    end else begin
      set_err_r <= bus.set_en && !legal_s;
    end
  end

  assign time_bcd    = time_r;
  assign alarm_bcd   = alarm_r;
  assign tick        = tick_r;
  assign ringing     = ringing_r;
  assign bus.set_err = set_err_r;

  assign hr12_s   = hour12_bcd(time_r);
  assign disp_bcd = h12 ? {hr12_s, time_r[15:0]} : time_r;
  assign pm       = is_pm(time_r);

  for (genvar g = 0; g < 6; g++) begin : g_ascii
    rtc_alarm_clock_num2ascii u_n2a (
      .digit (disp_bcd[4*g +: 4]),
      .ch    (ascii[8*g +: 8])
    );
  end

endmodule

// File: tb/tb_rtc_alarm_clock.sv
// Self-checking bench for rtc_alarm_clock (DIV = 4, RING_SECS = 2).
// The reference keeps time and alarm as seconds-of-day integers; a digit write
// is legal when the resulting value is still a valid HH:MM:SS time.
module tb_rtc_alarm_clock;

  localparam int DIV  = 4;
  localparam int RING = 2;
  localparam int DAY  = 86400;

  logic        clk;
  logic        clr;
  logic        run;
  logic        alarm_en;
  logic        alarm_ack;
  logic        h12;
  logic [23:0] time_bcd;
  logic [23:0] alarm_bcd;
  logic [23:0] disp_bcd;
  logic        pm;
  logic [47:0] ascii;
  logic        tick;
  logic        ringing;

  rtc_alarm_clock_if bus ();

  rtc_alarm_clock #(.CLK_FREQ(4), .TICK_HZ(1), .RING_SECS(RING)) dut (
    .CLOCK_50  (clk),
    .clr       (clr),
    .run       (run),
    .bus       (bus),
    .alarm_en  (alarm_en),
    .alarm_ack (alarm_ack),
    .h12       (h12),
    .time_bcd  (time_bcd),
    .alarm_bcd (alarm_bcd),
    .disp_bcd  (disp_bcd),
    .pm        (pm),
    .ascii     (ascii),
    .tick      (tick),
    .ringing   (ringing)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int errors = 0;
  int checks = 0;
  bit check_en = 1'b0;

  task automatic chk(input string name, input logic [47:0] act, input logic [47:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  int m_time = 0, m_alarm = 0, m_div = 0, m_rung = 0;
  bit m_tick = 1'b0, m_ring = 1'b0, m_err = 1'b0;
  int wr_res;

  function automatic logic [23:0] to_bcd(input int s);
    int hh, mm, ss;
    hh = s / 3600; mm = (s / 60) % 60; ss = s % 60;
    return {4'(hh / 10), 4'(hh % 10), 4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10)};
  endfunction

  // Returns the new seconds-of-day value, or -1 if the write is rejected.
  function automatic int try_write(input int base, input int sel, input int val);
    int d[6];
    int hh, mm, ss;
    hh = base / 3600; mm = (base / 60) % 60; ss = base % 60;
    d[0] = ss % 10; d[1] = ss / 10; d[2] = mm % 10;
    d[3] = mm / 10; d[4] = hh % 10; d[5] = hh / 10;
    if (sel > 5 || val > 9) return -1;
    d[sel] = val;
    hh = d[5] * 10 + d[4]; mm = d[3] * 10 + d[2]; ss = d[1] * 10 + d[0];
    if (hh > 23 || mm > 59 || ss > 59) return -1;
    return hh * 3600 + mm * 60 + ss;
  endfunction

  function automatic logic [23:0] exp_disp(input int s, input logic fmt12);
    logic [23:0] r;
    int h, dh;
    r = to_bcd(s);
    h = s / 3600;
    dh = (h % 12 == 0) ? 12 : h % 12;
    if (fmt12) r[23:16] = {4'(dh / 10), 4'(dh % 10)};
    return r;
  endfunction

  function automatic logic [47:0] exp_ascii(input logic [23:0] d);
    logic [47:0] a;
    for (int i = 0; i < 6; i++) a[8*i +: 8] = 8'h30 + {4'h0, d[4*i +: 4]};
    return a;
  endfunction

  always_comb wr_res = try_write(bus.set_tgt ? m_alarm : m_time, int'(bus.sel), int'(bus.load));

  always @(posedge clk or posedge clr) begin
    if (clr) begin
      m_time <= 0; m_alarm <= 0; m_div <= 0; m_rung <= 0;
      m_tick <= 1'b0; m_ring <= 1'b0; m_err <= 1'b0;
    end else begin
      m_err <= bus.set_en && (wr_res < 0);
      if (bus.set_en && wr_res >= 0 && !bus.set_tgt) begin
        m_time <= wr_res; m_div <= 0; m_tick <= 1'b0;
      end else if (run) begin
        if (m_div == DIV - 1) begin
          m_div <= 0; m_tick <= 1'b1; m_time <= (m_time + 1) % DAY;
        end else begin
          m_div <= m_div + 1; m_tick <= 1'b0;
        end
      end else begin
        m_tick <= 1'b0;
      end
      if (bus.set_en && wr_res >= 0 && bus.set_tgt) m_alarm <= wr_res;
      // rings for RING ticks after it starts, unless acked or disarmed
      if (alarm_ack || !alarm_en || (m_ring && m_tick && m_rung + 1 == RING)) begin
        m_ring <= 1'b0; m_rung <= 0;
      end else if (m_ring && m_tick) begin
        m_rung <= m_rung + 1;
      end else if (m_tick && alarm_en && m_time == m_alarm) begin
        m_ring <= 1'b1; m_rung <= 0;
      end
    end
  end

  // Cycle-by-cycle comparison on the falling edge
  always @(negedge clk) begin
    if (check_en) begin
      chk("time", time_bcd, to_bcd(m_time));
      chk("alarm", alarm_bcd, to_bcd(m_alarm));
      chk("tick", tick, m_tick);
      chk("ringing", ringing, m_ring);
      chk("set_err", bus.set_err, m_err);
      chk("disp", disp_bcd, exp_disp(m_time, h12));
      chk("pm", pm, (m_time >= 43200));
      chk("ascii", ascii, exp_ascii(exp_disp(m_time, h12)));
    end
  end

  // ---------------- stimulus ----------------
  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic wr(input bit tgt, input int s, input int v);
    bus.set_en = 1'b1; bus.set_tgt = tgt; bus.sel = 3'(s); bus.load = 4'(v);
    step(1);
    bus.set_en = 1'b0;
  endtask

  task automatic set_time(input int hh, input int mm, input int ss);
    wr(1'b0, 5, 0);
    wr(1'b0, 4, hh % 10);
    wr(1'b0, 5, hh / 10);
    wr(1'b0, 3, mm / 10);
    wr(1'b0, 2, mm % 10);
    wr(1'b0, 1, ss / 10);
    wr(1'b0, 0, ss % 10);
  endtask

  initial begin
    clr = 1'b1; run = 1'b0; alarm_en = 1'b0; alarm_ack = 1'b0; h12 = 1'b0;
    bus.set_en = 1'b0; bus.set_tgt = 1'b0; bus.sel = 3'd0; bus.load = 4'd0;
    step(3);
    chk("reset_time", time_bcd, 48'h0);
    chk("reset_tick", tick, 48'h0);
    clr = 1'b0; run = 1'b1; check_en = 1'b1;

    step(3);
    chk("no_tick_yet", tick, 48'h0);
    step(1);
    chk("t_after_4", time_bcd, 48'h000001);
    chk("first_tick", tick, 48'h1);
    step(36);
    chk("t_after_40", time_bcd, 48'h000010);

    set_time(23, 59, 59);
    chk("set_235959", time_bcd, 48'h235959);
    step(4);
    chk("wrap_day", time_bcd, 48'h000000);
    set_time(9, 59, 59);
    step(4);
    chk("wrap_hour", time_bcd, 48'h100000);

    set_time(22, 0, 0);
    wr(1'b0, 4, 9);
    chk("hr_lo9_err", bus.set_err, 48'h1);
    chk("hr_lo9_keep", time_bcd, 48'h220000);
    step(1);
    chk("err_one_cycle", bus.set_err, 48'h0);
    set_time(15, 0, 0);
    wr(1'b0, 5, 2);
    chk("hr_hi2_err", bus.set_err, 48'h1);
    chk("hr_hi2_keep", time_bcd, 48'h150000);
    wr(1'b0, 1, 6);
    chk("sec_hi6_keep", time_bcd, 48'h150000);
    wr(1'b0, 6, 1);
    chk("sel6_err", bus.set_err, 48'h1);
    step(1);

    // alarm at 00:00:03
    wr(1'b1, 0, 3);
    alarm_en = 1'b1;
    set_time(0, 0, 0);
    step(12);
    chk("alarm_time", time_bcd, 48'h000003);
    chk("alarm_pre_ring", ringing, 48'h0);
    step(1);
    chk("ring_rise", ringing, 48'h1);
    alarm_ack = 1'b1;
    step(1);
    alarm_ack = 1'b0;
    chk("ring_ack", ringing, 48'h0);
    set_time(0, 0, 0);
    step(13);
    chk("ring_rise2", ringing, 48'h1);
    step(7);
    chk("ring_hold", ringing, 48'h1);
    step(1);
    chk("ring_timeout", ringing, 48'h0);
    alarm_en = 1'b0;

    h12 = 1'b1;
    set_time(0, 0, 0);
    chk("h12_00", disp_bcd, 48'h120000);
    chk("h12_00_pm", pm, 48'h0);
    set_time(12, 0, 0);
    chk("h12_12", disp_bcd, 48'h120000);
    chk("h12_12_pm", pm, 48'h1);
    set_time(13, 0, 0);
    chk("h12_13", disp_bcd, 48'h010000);
    chk("h12_13_ascii", ascii[47:32], 48'h3031);
    set_time(23, 0, 0);
    chk("h12_23", disp_bcd, 48'h110000);
    chk("h12_23_pm", pm, 48'h1);
    h12 = 1'b0;

    // time write landing on the tick cycle
    set_time(1, 2, 3);
    step(3);
    wr(1'b0, 2, 5);
    chk("coinc_val", time_bcd, 48'h010503);
    chk("coinc_notick", tick, 48'h0);
    step(3);
    chk("coinc_restart", tick, 48'h0);
    step(1);
    chk("coinc_tick", tick, 48'h1);
    chk("coinc_adv", time_bcd, 48'h010504);

    // asynchronous clear in mid-cycle
    clr = 1'b1;
    #1;
    chk("clr_time", time_bcd, 48'h0);
    chk("clr_alarm", alarm_bcd, 48'h0);
    chk("clr_tick", tick, 48'h0);
    chk("clr_ring", ringing, 48'h0);
    chk("clr_err", bus.set_err, 48'h0);
    step(1);
    clr = 1'b0;

    for (int i = 0; i < 3000; i++) begin
      run         = ($urandom_range(0, 9) != 0);
      bus.set_en  = ($urandom_range(0, 3) == 0);
      bus.set_tgt = 1'($urandom_range(0, 1));
      bus.sel     = 3'($urandom_range(0, 6));
      bus.load    = ($urandom_range(0, 4) == 0) ? 4'($urandom_range(0, 15)) : 4'($urandom_range(0, 5));
      alarm_en    = ($urandom_range(0, 15) != 0);
      alarm_ack   = ($urandom_range(0, 31) == 0);
      h12         = 1'($urandom_range(0, 1));
      clr         = ($urandom_range(0, 599) == 0);
      step(1);
    end
    clr = 1'b0; bus.set_en = 1'b0;
    step(1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
